// File: rtl/sd_pkg.sv
// Shared types and reset-time configuration constants for the serial
// pattern detector.
package sd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } sd_state_e;

   // Reset pattern 1001001001, zero-extended to the widest supported length.
   localparam logic [15:0] DEF_PAT = 16'b0000_0010_0100_1001;
   localparam int          DEF_LEN = 10;
   localparam logic        DEF_OVL = 1'b1;

endpackage

// File: rtl/sd_hist_match.sv
// Serial history shift register with a length-masked compare of the
// post-shift history against the configured pattern.
module sd_hist_match #(
   parameter int MAX_LEN = 10,
   parameter int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr_i,
   input  logic               shift_i,
   input  logic               x_i,
   input  logic [MAX_LEN-1:0] pat_i,
   input  logic [LW-1:0]      len_i,
   output logic               eq_o
);

   logic [MAX_LEN-1:0] hist_q;
   logic [MAX_LEN-1:0] hist_d;
   logic [MAX_LEN-1:0] hist_nxt_s;
   logic [MAX_LEN-1:0] mask_s;

   // Newest bit enters at [0]; the compare looks at the value after this shift.
   always_comb begin
      hist_nxt_s = {hist_q[MAX_LEN-2:0], x_i};
      mask_s     = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask_s[i] = (i < int'(len_i));
      end
      eq_o = (((hist_nxt_s ^ pat_i) & mask_s) == '0);
   end

   // Next history: clear on arm, shift on valid sample, else hold.
   always_comb begin
      if (clr_i) begin
         hist_d = '0;
      end else if (shift_i) begin
         hist_d = hist_nxt_s;
      end else begin
         hist_d = hist_q;
      end
   end

   // History register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

endmodule

// File: rtl/sd_cfg_ctrl.sv
// Configurable serial pattern detector: IDLE/FILL/RUN control, configuration
// registers, saturating match counter and registered match/error pulses.
module sd_cfg_ctrl
   import sd_pkg::*;
#(
   parameter int MAX_LEN = 10,
   parameter int CNT_W   = 8,
   localparam int LW     = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pat,
   input  logic [LW-1:0]      cfg_len,
   input  logic               cfg_ovl,
   input  logic               start,
   input  logic               stop,
   input  logic               x,
   input  logic               x_vld,
   output logic               y,
   output logic               busy,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cfg_err
);

   sd_state_e          state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LW-1:0]      len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [LW-1:0]      fill_q, fill_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               y_q, y_d;
   logic               err_q, err_d;
   logic [LW-1:0]      fill_inc_s;
   logic               len_ok_s;
   logic               clr_s;
   logic               shift_s;
   logic               eq_s;

   assign len_ok_s = (cfg_len >= LW'(2)) && (cfg_len <= LW'(MAX_LEN));

   sd_hist_match #(
      .MAX_LEN (MAX_LEN),
      .LW      (LW)
   ) u_hist (
      .clk     (clk),
      .rst_n   (rst),
      .clr_i   (clr_s),
      .shift_i (shift_s),
      .x_i     (x),
      .pat_i   (pat_q),
      .len_i   (len_q),
      .eq_o    (eq_s)
   );

   // Next-state, configuration, counter and pulse logic.
   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      len_d      = len_q;
      ovl_d      = ovl_q;
      fill_d     = fill_q;
      cnt_d      = cnt_q;
      y_d        = 1'b0;
      err_d      = 1'b0;
      clr_s      = 1'b0;
      shift_s    = 1'b0;
      fill_inc_s = fill_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_we && len_ok_s) begin
               pat_d = cfg_pat;
               len_d = cfg_len;
               ovl_d = cfg_ovl;
            end else begin
               err_d = cfg_we;
            end
            if (start) begin
               clr_s   = 1'b1;
               fill_d  = '0;
               cnt_d   = '0;
               state_d = ST_FILL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FILL, ST_RUN: begin
            // Stop overrides any cfg_we or sample arriving in the same cycle.
            if (stop) begin
               state_d = ST_IDLE;
            end else if (x_vld) begin
               err_d      = cfg_we;
               shift_s    = 1'b1;
               fill_inc_s = (fill_q >= len_q) ? fill_q : fill_q + LW'(1);
               fill_d     = fill_inc_s;
               if (fill_inc_s >= len_q) begin
                  state_d = ST_RUN;
                  if (eq_s) begin
                     y_d   = 1'b1;
                     cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                     if (!ovl_q) begin
                        fill_d  = '0;
                        state_d = ST_FILL;
                     end else begin
                        state_d = ST_RUN;
                     end
                  end else begin
                     y_d = 1'b0;
                  end
               end else begin
                  state_d = ST_FILL;
               end
            end else begin
               err_d = cfg_we;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, configuration and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         pat_q   <= DEF_PAT[MAX_LEN-1:0];
         len_q   <= LW'(DEF_LEN);
         ovl_q   <= DEF_OVL;
         fill_q  <= '0;
         cnt_q   <= '0;
         y_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         err_q   <= err_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign y         = y_q;
   assign match_cnt = cnt_q;
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_sd_cfg_ctrl.sv
// Scoreboard bench for sd_cfg_ctrl: a default instance and a CNT_W=4
// instance share all inputs; a sequence-level model predicts every output.
module tb_sd_cfg_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cfg_we = 1'b0;
   logic [9:0] cfg_pat = '0;
   logic [3:0] cfg_len = '0;
   logic       cfg_ovl = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       x = 1'b0;
   logic       x_vld = 1'b0;
   logic       y, busy, cfg_err;
   logic [7:0] match_cnt;
   logic       y4, busy4, cfg_err4;
   logic [3:0] match_cnt4;

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] mdl_pat;
   int          mdl_len;
   logic        mdl_ovl;
   logic        mdl_armed;
   int          mdl_cnt;
   logic        hist[$];
   logic        exp_q[$];
   int          y_pulses;

   always #5 clk = ~clk;

   sd_cfg_ctrl u_dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
      .cfg_ovl(cfg_ovl), .start(start), .stop(stop), .x(x), .x_vld(x_vld),
      .y(y), .busy(busy), .match_cnt(match_cnt), .cfg_err(cfg_err)
   );

   sd_cfg_ctrl #(.MAX_LEN(10), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
      .cfg_ovl(cfg_ovl), .start(start), .stop(stop), .x(x), .x_vld(x_vld),
      .y(y4), .busy(busy4), .match_cnt(match_cnt4), .cfg_err(cfg_err4)
   );

   task automatic model_reset();
      mdl_pat   = 16'b0000_0010_0100_1001;
      mdl_len   = 10;
      mdl_ovl   = 1'b1;
      mdl_armed = 1'b0;
      mdl_cnt   = 0;
      hist.delete();
      exp_q.delete();
   endtask

   task automatic check_cnt(input string name);
      int e8, e4;
      e8 = (mdl_cnt > 255) ? 255 : mdl_cnt;
      e4 = (mdl_cnt > 15) ? 15 : mdl_cnt;
      n_chk++;
      if (match_cnt !== 8'(e8)) begin
         n_fail++;
         $display("FAIL %s match_cnt: got %0d expected %0d", name, match_cnt, e8);
      end
      n_chk++;
      if (match_cnt4 !== 4'(e4)) begin
         n_fail++;
         $display("FAIL %s match_cnt4: got %0d expected %0d", name, match_cnt4, e4);
      end
   endtask

   task automatic check_busy(input string name);
      n_chk++;
      if (busy !== mdl_armed || busy4 !== mdl_armed) begin
         n_fail++;
         $display("FAIL %s busy: got %b/%b expected %b", name, busy, busy4, mdl_armed);
      end
   endtask

   // One cycle of sample stimulus; expectation queued now, compared after the edge.
   task automatic drive_bit(input logic b, input logic v, input string name);
      logic e, got_e, ok;
      int   n;
      e = 1'b0;
      x = b;
      x_vld = v;
      if (mdl_armed && v) begin
         hist.push_back(b);
         n = hist.size();
         if (n >= mdl_len) begin
            ok = 1'b1;
            for (int k = 0; k < mdl_len; k++) begin
               if (hist[n - mdl_len + k] !== mdl_pat[mdl_len - 1 - k]) ok = 1'b0;
            end
            if (ok) begin
               e = 1'b1;
               mdl_cnt++;
               if (!mdl_ovl) hist.delete();
            end
         end
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      x_vld = 1'b0;
      got_e = exp_q.pop_front();
      if (y === 1'b1) y_pulses++;
      n_chk++;
      if (y !== got_e || y4 !== got_e) begin
         n_fail++;
         $display("FAIL %s y: got %b/%b expected %b", name, y, y4, got_e);
      end
   endtask

   task automatic cfg_write(input logic [9:0] p, input logic [3:0] l, input logic o,
                            input string name);
      logic acc;
      acc = !mdl_armed && (l >= 4'd2) && (l <= 4'd10);
      cfg_pat = p; cfg_len = l; cfg_ovl = o; cfg_we = 1'b1;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      if (acc) begin
         mdl_pat = {6'b0, p};
         mdl_len = int'(l);
         mdl_ovl = o;
      end
      n_chk++;
      if (cfg_err !== !acc || cfg_err4 !== !acc) begin
         n_fail++;
         $display("FAIL %s cfg_err: got %b/%b expected %b", name, cfg_err, cfg_err4, !acc);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s cfg_err_clear: got %b expected 0", name, cfg_err);
      end
   endtask

   task automatic arm(input string name);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      mdl_armed = 1'b1;
      mdl_cnt   = 0;
      hist.delete();
      check_busy(name);
      check_cnt(name);
   endtask

   task automatic disarm(input string name);
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      mdl_armed = 1'b0;
      check_busy(name);
   endtask

   task automatic send_stream(input logic [12:0] s, input int nbits, input int gap,
                              input string name);
      for (int i = 0; i < nbits; i++) begin
         drive_bit(s[12 - i], 1'b1, name);
         for (int g = 0; g < gap; g++) drive_bit(1'($urandom_range(0, 1)), 1'b0, name);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (y !== 1'b0 || cfg_err !== 1'b0 || busy !== 1'b0 || match_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset: got y=%b err=%b busy=%b cnt=%0d expected all 0",
                  y, cfg_err, busy, match_cnt);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_busy("reset_release");
   endtask

   task automatic test_default_ovl();
      arm("ovl_arm");
      send_stream(13'b1001001001001, 13, 0, "ovl");
      check_cnt("ovl");
      n_chk++;
      if (mdl_cnt !== 2) begin
         n_fail++;
         $display("FAIL ovl_expected_matches: got %0d expected 2", mdl_cnt);
      end
      disarm("ovl_stop");
   endtask

   task automatic test_nonovl();
      cfg_write(10'b1001001001, 4'd10, 1'b0, "novl_cfg");
      arm("novl_arm");
      send_stream(13'b1001001001001, 13, 0, "novl");
      check_cnt("novl");
      disarm("novl_stop");
   endtask

   task automatic test_cfg_err();
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      cfg_write(10'b0000000011, 4'd1, 1'b0, "err_len1");
      arm("err_arm");
      cfg_write(10'b0000000101, 4'd3, 1'b0, "err_run");
      send_stream(13'b1001001001001, 13, 0, "err_defaults");
      check_cnt("err_defaults");
      disarm("err_stop");
   endtask

   task automatic test_saturate();
      cfg_write(10'b0000000011, 4'd2, 1'b1, "sat_cfg");
      arm("sat_arm");
      y_pulses = 0;
      for (int i = 0; i < 20; i++) drive_bit(1'b1, 1'b1, "sat");
      check_cnt("sat");
      n_chk++;
      if (y_pulses !== 19) begin
         n_fail++;
         $display("FAIL sat_pulses: got %0d expected 19", y_pulses);
      end
      disarm("sat_stop");
   endtask

   task automatic test_gaps();
      cfg_write(10'b1001001001, 4'd10, 1'b1, "gap_cfg");
      arm("gap_arm");
      send_stream(13'b1001001001000, 10, 3, "gap");
      check_cnt("gap");
      disarm("gap_stop");
   endtask

   task automatic test_rst_mid();
      arm("rmid_arm");
      send_stream(13'b1001001001000, 9, 0, "rmid");
      rst = 1'b0;
      model_reset();
      #2;
      check_busy("rmid_async");
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive_bit(1'b1, 1'b1, "rmid_bit10");
      drive_bit(1'b0, 1'b1, "rmid_after");
      check_busy("rmid_end");
      check_cnt("rmid_end");
   endtask

   initial begin
      test_reset();
      test_default_ovl();
      test_nonovl();
      test_cfg_err();
      test_saturate();
      test_gaps();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sd_cfg_ctrl.md
SD_CFG_CTRL -- requirements
Module: sd_cfg_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 10, maximum pattern length in bits (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of match counter.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-006 SHALL have port cfg_pat  input  MAX_LEN  pattern; bit [len-1] is first serial bit expected.
REQ-007 SHALL have port cfg_len  input  $clog2(MAX_LEN+1)  pattern length.
REQ-008 SHALL have port cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port start  input  1  arm detector.
REQ-010 SHALL have port stop  input  1  disarm detector.
REQ-011 SHALL have port x  input  1  serial data bit.
REQ-012 SHALL have port x_vld  input  1  x valid qualifier; x ignored when 0.
REQ-013 SHALL have port y  output  1  registered one-cycle match pulse.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port match_cnt  output  CNT_W  matches since last start, saturating.
REQ-016 SHALL have port cfg_err  output  1  one-cycle pulse on rejected cfg_we.

Function
REQ-017 SHALL implement states IDLE, FILL, RUN; FILL = fewer than len valid bits held, RUN = at least len bits held.
REQ-018 SHALL accept cfg_we only in IDLE with 2 <= cfg_len <= MAX_LEN, latching pat/len/ovl next edge.
REQ-019 SHALL, on cfg_we outside IDLE or with illegal cfg_len, keep old config and pulse cfg_err the following cycle.
REQ-020 SHALL, on start in IDLE, clear history, fill count and match_cnt and enter FILL next edge; start outside IDLE is ignored.
REQ-021 SHALL, on stop in FILL or RUN, enter IDLE next edge; stop has priority over start, cfg_we and any x_vld that cycle.
REQ-022 SHALL shift x into history only on x_vld=1 in FILL or RUN; fill count increments to len then holds, FILL->RUN when it reaches len.
REQ-023 SHALL declare a match when the shifted-in sample makes history[len-1:0] == cfg_pat[len-1:0] with fill count >= len.
REQ-024 SHALL assert y exactly one cycle, the cycle after the matching x_vld edge (latency 1); y never asserted in IDLE.
REQ-025 SHALL, on a match with ovl=1, stay in RUN keeping history; with ovl=0, clear fill count and return to FILL.
REQ-026 SHALL increment match_cnt per match and saturate at all-ones without wrap.
REQ-027 SHALL treat x_vld=0 cycles as stalls: no shift, no state change except stop.
REQ-028 SHALL drive busy combinationally from state register only.

Reset
REQ-029 SHALL, while rst=0, force state IDLE, y=0, cfg_err=0, match_cnt=0, history=0, fill count=0.
REQ-030 SHALL reset config to pat=MAX_LEN'b1001001001 (zero-extended), len=10, ovl=1.
REQ-031 SHALL, on reset asserted mid-stream, abort immediately; no y pulse after rst release until a new start.

Structure
REQ-032 SHALL place state enumeration and default pattern/length constants in shared package sd_pkg.
REQ-033 SHALL isolate history shift register plus length-masked compare in sub-module sd_hist_match.

Verification
REQ-034 SHALL test default config, start, stream 1001001001001 with x_vld=1 -> y after bit 10 and bit 13, match_cnt=2.
REQ-035 SHALL test ovl=0, same stream -> single y after bit 10, match_cnt=1.
REQ-036 SHALL test cfg_len=1 in IDLE, and cfg_we in RUN -> cfg_err pulse each, config unchanged (defaults still detect).
REQ-037 SHALL test pat=2'b11, len=2, ovl=1, CNT_W=4, 20 ones -> 19 y pulses, match_cnt saturates at 15.
REQ-038 SHALL test x_vld gaps of 3 cycles between bits of 1001001001 -> y only after tenth valid bit.
REQ-039 SHALL test rst low after bit 9, then release and continue bit 10 -> no y, busy=0, match_cnt=0.
